border_message_router: RTL and testbench

BORDER_MESSAGE_ROUTER -- requirements
Module: border_message_router

---
 rtl/border_message_router.sv | 212 +++++++++++++++++++++
 tb/tb_border_message_router.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/border_message_router.sv
// border_message_router
//   Bridges a row of border PE channels and a controller port onto one
//   parent link.
//   - Outbound: control words and border payloads share one registered tx
//     stage. Control has priority, but after CTRL_BURST_LIMIT control grants
//     a waiting border channel is served. Border channels are served
//     round-robin.
//   - Inbound: rx words are steered combinationally. Bit LINK_WIDTH-1 = 0
//     sends the word to ctrl_out. Otherwise the 8-bit index field picks a
//     border_out channel. An index with no channel is accepted and dropped.
//   Handshakes: every port uses valid/ready. A word transfers on a rising
//   clk edge where valid and ready are both high. A source that raises valid
//   holds its data stable until that transfer.
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   border_in_*              PE -> router payloads, channel i at slice i
//   border_out_*             router -> PE payloads
//   ctrl_in_*                controller -> link words
//   ctrl_out_*               link -> controller words
//   tx_*                     parent link transmit (registered)
//   rx_*                     parent link receive (combinational routing)
//   router_busy              activity indicator with BUSY_HOLD tail
//   drop_count, drop_error   saturating count and sticky flag of dropped rx words
module border_message_router #(
    parameter int NUM_CHANNELS     = 9,
    parameter int CHANNEL_WIDTH    = 11,
    parameter int LINK_WIDTH       = 64,
    parameter int BUSY_HOLD        = 18,
    parameter int CTRL_BURST_LIMIT = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   border_in_data,
    input  logic [NUM_CHANNELS-1:0]                 border_in_valid,
    output logic [NUM_CHANNELS-1:0]                 border_in_ready,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   border_out_data,
    output logic [NUM_CHANNELS-1:0]                 border_out_valid,
    input  logic [NUM_CHANNELS-1:0]                 border_out_ready,
    input  logic [LINK_WIDTH-1:0]                   ctrl_in_data,
    input  logic                                    ctrl_in_valid,
    output logic                                    ctrl_in_ready,
    output logic [LINK_WIDTH-1:0]                   ctrl_out_data,
    output logic                                    ctrl_out_valid,
    input  logic                                    ctrl_out_ready,
    output logic [LINK_WIDTH-1:0]                   tx_data,
    output logic                                    tx_valid,
    input  logic                                    tx_ready,
    input  logic [LINK_WIDTH-1:0]                   rx_data,
    input  logic                                    rx_valid,
    output logic                                    rx_ready,
    output logic                                    router_busy,
    output logic [15:0]                             drop_count,
    output logic                                    drop_error
);
    localparam int IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int BURST_W = $clog2(CTRL_BURST_LIMIT + 1);
    localparam int BUSY_W  = $clog2(BUSY_HOLD + 1);

    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         rr_sel;
    logic [IDX_W-1:0]         cand;
    logic                     rr_found;
    logic [CHANNEL_WIDTH-1:0] rr_payload;
    logic                     any_border;
    logic                     can_load;
    logic                     burst_full;
    logic                     ctrl_win;
    logic                     border_win;
    logic                     ctrl_grant;
    logic                     border_grant;
    logic [BURST_W-1:0]       burst_cnt;
    logic [BUSY_W-1:0]        busy_cnt;
    logic [LINK_WIDTH-1:0]    border_word;
    logic [LINK_WIDTH-1:0]    ctrl_word;
    logic [7:0]               rx_idx;
    logic                     rx_is_border;
    logic                     rx_in_range;
    logic                     tx_fire;
    logic                     rx_fire;
    logic                     drop;

    // ------------------------------------------------------------------
    // Outbound arbitration
    // ------------------------------------------------------------------
    assign any_border = |border_in_valid;
    // The stage can take a new word when it is empty or is draining this cycle.
    assign can_load   = !tx_valid || tx_ready;
    assign burst_full = (burst_cnt == BURST_W'(CTRL_BURST_LIMIT));
    assign ctrl_win   = ctrl_in_valid && !(burst_full && any_border);
    assign border_win = rr_found && !ctrl_win;
    assign ctrl_grant   = ctrl_win && can_load;
    assign border_grant = border_win && can_load;

    // Round-robin search, starting just after the last granted channel.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand = IDX_W'((int'(last_grant) + k + 1) % NUM_CHANNELS);
            if (!rr_found && border_in_valid[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    always_comb begin
        rr_payload      = '0;
        border_in_ready = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rr_sel == IDX_W'(i)) begin
                rr_payload         = border_in_data[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                border_in_ready[i] = border_grant;
            end
        end
    end

    assign ctrl_in_ready = ctrl_grant;

    always_comb begin
        border_word                          = '0;
        border_word[LINK_WIDTH-1]            = 1'b1;
        border_word[LINK_WIDTH-2 -: 8]       = 8'(rr_sel);
        border_word[CHANNEL_WIDTH-1:0]       = rr_payload;
        ctrl_word                            = ctrl_in_data;
        ctrl_word[LINK_WIDTH-1]              = 1'b0;
    end

    // ------------------------------------------------------------------
    // Inbound routing
    // ------------------------------------------------------------------
    assign rx_is_border    = rx_data[LINK_WIDTH-1];
    assign rx_idx          = rx_data[LINK_WIDTH-2 -: 8];
    assign rx_in_range     = ({1'b0, rx_idx} < 9'(NUM_CHANNELS));
    assign ctrl_out_data   = rx_data;
    // Every channel sees the payload; only the addressed one sees valid.
    assign border_out_data = {NUM_CHANNELS{rx_data[CHANNEL_WIDTH-1:0]}};

    always_comb begin
        border_out_valid = '0;
        ctrl_out_valid   = 1'b0;
        rx_ready         = 1'b0;
        if (!rx_is_border) begin
            ctrl_out_valid = rx_valid;
            rx_ready       = ctrl_out_ready;
        end else if (!rx_in_range) begin
            // No channel at this index. Accept the word so the link cannot stall.
            rx_ready = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (rx_idx == 8'(i)) begin
                    border_out_valid[i] = rx_valid;
                    rx_ready            = border_out_ready[i];
                end
            end
        end
    end

    assign tx_fire     = tx_valid && tx_ready;
    assign rx_fire     = rx_valid && rx_ready;
    assign drop        = rx_valid && rx_is_border && !rx_in_range;
    assign router_busy = tx_valid || rx_valid || ctrl_in_valid || any_border || (busy_cnt != '0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            last_grant <= IDX_W'(NUM_CHANNELS - 1);
            burst_cnt  <= '0;
            busy_cnt   <= '0;
            drop_count <= '0;
            drop_error <= 1'b0;
        end else begin
            if (can_load) begin
                tx_valid <= ctrl_grant || border_grant;
                if (ctrl_grant) begin
                    tx_data <= ctrl_word;
                end else if (border_grant) begin
                    tx_data <= border_word;
                end
            end

            if (border_grant) begin
                last_grant <= rr_sel;
            end

            // The burst counter tracks only control grants taken while border traffic waits.
            if (border_grant || !any_border) begin
                burst_cnt <= '0;
            end else if (ctrl_grant) begin
                burst_cnt <= burst_cnt + 1'b1;
            end

            if (tx_fire || rx_fire) begin
                busy_cnt <= BUSY_W'(BUSY_HOLD);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
            end

            if (drop) begin
                drop_error <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_border_message_router.sv
// tb_border_message_router
//   Directed scenarios for border_message_router with default parameters.
//   Expected tx words are pushed into exp_q when a scenario starts. They are
//   popped and compared whenever tx_valid && tx_ready is seen. Sources follow
//   the valid/ready rule: a channel's payload advances only after that
//   channel has completed a handshake.
module tb_border_message_router;
    localparam int N  = 9;
    localparam int CW = 11;
    localparam int LW = 64;
    localparam int BH = 18;
    localparam int BL = 4;

    logic              clk;
    logic              reset;
    logic [N*CW-1:0]   border_in_data;
    logic [N-1:0]      border_in_valid;
    logic [N-1:0]      border_in_ready;
    logic [N*CW-1:0]   border_out_data;
    logic [N-1:0]      border_out_valid;
    logic [N-1:0]      border_out_ready;
    logic [LW-1:0]     ctrl_in_data;
    logic              ctrl_in_valid;
    logic              ctrl_in_ready;
    logic [LW-1:0]     ctrl_out_data;
    logic              ctrl_out_valid;
    logic              ctrl_out_ready;
    logic [LW-1:0]     tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [LW-1:0]     rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              router_busy;
    logic [15:0]       drop_count;
    logic              drop_error;

    int tests_run;
    int tests_failed;
    int sent_b[N];
    int sent_c;
    logic [LW-1:0] exp_q[$];

    border_message_router #(
        .NUM_CHANNELS(N), .CHANNEL_WIDTH(CW), .LINK_WIDTH(LW),
        .BUSY_HOLD(BH), .CTRL_BURST_LIMIT(BL)
    ) dut (
        .clk(clk), .reset(reset),
        .border_in_data(border_in_data), .border_in_valid(border_in_valid),
        .border_in_ready(border_in_ready),
        .border_out_data(border_out_data), .border_out_valid(border_out_valid),
        .border_out_ready(border_out_ready),
        .ctrl_in_data(ctrl_in_data), .ctrl_in_valid(ctrl_in_valid),
        .ctrl_in_ready(ctrl_in_ready),
        .ctrl_out_data(ctrl_out_data), .ctrl_out_valid(ctrl_out_valid),
        .ctrl_out_ready(ctrl_out_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .router_busy(router_busy), .drop_count(drop_count), .drop_error(drop_error)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    function automatic logic [CW-1:0] pay(input int c, input int n);
        return CW'(c * 37 + n * 5 + 1);
    endfunction

    function automatic logic [LW-1:0] bword(input int c, input int n);
        logic [LW-1:0] w;
        w = '0;
        w[LW-1] = 1'b1;
        w[LW-2 -: 8] = 8'(c);
        w[CW-1:0] = pay(c, n);
        return w;
    endfunction

    function automatic logic [LW-1:0] cin(input int n);
        return {1'b1, 63'h25A5_0F0F_0000_0000 + 63'(n)};
    endfunction

    function automatic logic [LW-1:0] cexp(input int n);
        return {1'b0, 63'h25A5_0F0F_0000_0000 + 63'(n)};
    endfunction

    task automatic drive_data();
        for (int c = 0; c < N; c++) border_in_data[c*CW +: CW] = pay(c, sent_b[c]);
        ctrl_in_data = cin(sent_c);
    endtask

    // Called at a negedge: note handshakes, cross the edge, advance the sources.
    task automatic step();
        logic [N-1:0] hs_b;
        logic hs_c;
        hs_b = border_in_valid & border_in_ready;
        hs_c = ctrl_in_valid & ctrl_in_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) if (hs_b[c]) sent_b[c]++;
        if (hs_c) sent_c++;
        drive_data();
    endtask

    task automatic apply_reset();
        border_in_valid  = '0;
        border_out_ready = '0;
        ctrl_in_valid    = 1'b0;
        ctrl_out_ready   = 1'b0;
        tx_ready         = 1'b0;
        rx_data          = '0;
        rx_valid         = 1'b0;
        for (int c = 0; c < N; c++) sent_b[c] = 0;
        sent_c = 0;
        drive_data();
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        tests_run++; if (tx_data !== '0) begin tests_failed++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        tests_run++; if (drop_error !== 1'b0) begin tests_failed++; $display("FAIL reset_drop_error: got %b expected 0", drop_error); end
        tests_run++; if (router_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", router_busy); end
        tests_run++; if (border_in_ready !== '0) begin tests_failed++; $display("FAIL reset_border_ready: got %b expected 0", border_in_ready); end
        tests_run++; if (ctrl_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ctrl_ready: got %b expected 0", ctrl_in_ready); end
        tests_run++; if (border_out_valid !== '0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", border_out_valid); end
    endtask

    task automatic test_round_robin();
        logic [LW-1:0] exp_w;
        int pops;
        int chs[3];
        apply_reset();
        chs[0] = 0; chs[1] = 3; chs[2] = 5;
        for (int j = 0; j < 6; j++) exp_q.push_back(bword(chs[j % 3], j / 3));
        border_in_valid = 9'b0_0010_1001;
        tx_ready = 1'b1;
        drive_data();
        pops = 0;
        for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_cycle0_valid: got %b expected 0", tx_valid); end
            end
            if (tx_valid && tx_ready) begin
                tests_run++;
                exp_w = exp_q.pop_front();
                if (tx_data !== exp_w || cyc != pops + 1) begin
                    tests_failed++;
                    $display("FAIL rr_tx_word: got %h at cycle %0d expected %h at cycle %0d", tx_data, cyc, exp_w, pops + 1);
                end
                pops++;
            end
            step();
        end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rr_timeout: got %0d words left expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_ctrl_burst();
        logic [LW-1:0] exp_w;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < BL; k++) exp_q.push_back(cexp(r * BL + k));
            exp_q.push_back(bword(2, r));
        end
        ctrl_in_valid = 1'b1;
        border_in_valid = 9'b0_0000_0100;
        tx_ready = 1'b1;
        drive_data();
        for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                tests_run++;
                exp_w = exp_q.pop_front();
                if (tx_data !== exp_w) begin tests_failed++; $display("FAIL burst_tx_word: got %h expected %h", tx_data, exp_w); end
            end
            step();
        end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL burst_timeout: got %0d words left expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] exp_w;
        apply_reset();
        for (int k = 0; k < BL; k++) exp_q.push_back(cexp(k));
        exp_q.push_back(bword(0, 0));
        for (int k = BL; k < 2 * BL; k++) exp_q.push_back(cexp(k));
        exp_q.push_back(bword(1, 0));
        ctrl_in_valid = 1'b1;
        border_in_valid = '1;
        tx_ready = 1'b0;
        drive_data();
        @(negedge clk);
        tests_run++; if (ctrl_in_ready !== 1'b1 || border_in_ready !== '0) begin
            tests_failed++; $display("FAIL bp_first_grant: got ctrl %b border %b expected ctrl 1 border 0", ctrl_in_ready, border_in_ready);
        end
        step();
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            tests_run++; if (tx_valid !== 1'b1 || tx_data !== cexp(0)) begin
                tests_failed++; $display("FAIL bp_stall_hold: got %b/%h expected 1/%h", tx_valid, tx_data, cexp(0));
            end
            tests_run++; if (ctrl_in_ready !== 1'b0 || border_in_ready !== '0) begin
                tests_failed++; $display("FAIL bp_stall_ready: got ctrl %b border %b expected all 0", ctrl_in_ready, border_in_ready);
            end
            step();
        end
        tx_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                tests_run++;
                exp_w = exp_q.pop_front();
                if (tx_data !== exp_w) begin tests_failed++; $display("FAIL bp_tx_word: got %h expected %h", tx_data, exp_w); end
            end
            step();
        end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL bp_timeout: got %0d words left expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_rx_routing();
        logic [LW-1:0] w;
        apply_reset();
        rx_data = 64'h0123_4567_89AB_CDEF;
        rx_valid = 1'b1;
        @(negedge clk);
        tests_run++; if (ctrl_out_valid !== 1'b1 || ctrl_out_data !== 64'h0123_4567_89AB_CDEF) begin
            tests_failed++; $display("FAIL rx_ctrl_route: got %b/%h expected 1/0123456789abcdef", ctrl_out_valid, ctrl_out_data);
        end
        tests_run++; if (rx_ready !== 1'b0 || border_out_valid !== '0) begin
            tests_failed++; $display("FAIL rx_ctrl_blocked: got ready %b out_valid %b expected 0/0", rx_ready, border_out_valid);
        end
        @(posedge clk); #1;
        ctrl_out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL rx_ctrl_ready: got %b expected 1", rx_ready); end
        @(posedge clk); #1;
        w = '0; w[63] = 1'b1; w[62:55] = 8'd4; w[10:0] = 11'h5A3;
        rx_data = w;
        border_out_ready = 9'h100;
        @(negedge clk);
        tests_run++; if (border_out_valid !== 9'h010 || ctrl_out_valid !== 1'b0 || rx_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rx_border4_route: got %h/%b/%b expected 010/0/0", border_out_valid, ctrl_out_valid, rx_ready);
        end
        tests_run++; if (border_out_data[4*CW +: CW] !== 11'h5A3) begin
            tests_failed++; $display("FAIL rx_border4_data: got %h expected 5a3", border_out_data[4*CW +: CW]);
        end
        @(posedge clk); #1;
        border_out_ready = 9'h010;
        @(negedge clk);
        tests_run++; if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL rx_border4_ready: got %b expected 1", rx_ready); end
        @(posedge clk); #1;
        w[62:55] = 8'd8;
        rx_data = w;
        border_out_ready = 9'h100;
        @(negedge clk);
        tests_run++; if (border_out_valid !== 9'h100 || rx_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rx_border8_route: got %h/%b expected 100/1", border_out_valid, rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (drop_count !== 16'd0 || drop_error !== 1'b0) begin
            tests_failed++; $display("FAIL rx_no_drop: got %0d/%b expected 0/0", drop_count, drop_error);
        end
    endtask

    task automatic test_drop();
        logic [LW-1:0] w;
        apply_reset();
        w = '0; w[63] = 1'b1; w[62:55] = 8'd200; w[10:0] = 11'h7FF;
        rx_data = w;
        rx_valid = 1'b1;
        border_out_ready = '1;
        @(negedge clk);
        tests_run++; if (rx_ready !== 1'b1 || border_out_valid !== '0 || ctrl_out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL drop200_outputs: got ready %b out %h ctrl %b expected 1/000/0", rx_ready, border_out_valid, ctrl_out_valid);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (drop_count !== 16'd1 || drop_error !== 1'b1) begin
            tests_failed++; $display("FAIL drop200_count: got %0d/%b expected 1/1", drop_count, drop_error);
        end
        @(posedge clk); #1;
        w[62:55] = 8'd9;
        rx_data = w;
        rx_valid = 1'b1;
        @(negedge clk);
        tests_run++; if (rx_ready !== 1'b1 || border_out_valid !== '0) begin
            tests_failed++; $display("FAIL drop9_outputs: got ready %b out %h expected 1/000", rx_ready, border_out_valid);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (drop_count !== 16'd2 || drop_error !== 1'b1) begin
            tests_failed++; $display("FAIL drop9_count: got %0d/%b expected 2/1", drop_count, drop_error);
        end
    endtask

    task automatic test_busy_hold();
        int high;
        logic seen_low;
        logic rerise;
        apply_reset();
        @(negedge clk);
        tests_run++; if (router_busy !== 1'b0) begin tests_failed++; $display("FAIL busy_idle: got %b expected 0", router_busy); end
        @(posedge clk); #1;
        rx_data = 64'h0000_0000_0000_0042;
        rx_valid = 1'b1;
        ctrl_out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (router_busy !== 1'b1) begin tests_failed++; $display("FAIL busy_rx_valid: got %b expected 1", router_busy); end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        high = 0; seen_low = 1'b0; rerise = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (router_busy) begin
                if (seen_low) rerise = 1'b1;
                else high++;
            end else begin
                seen_low = 1'b1;
            end
        end
        tests_run++; if (high != BH) begin tests_failed++; $display("FAIL busy_hold_len: got %0d expected %0d", high, BH); end
        tests_run++; if (rerise !== 1'b0 || router_busy !== 1'b0) begin
            tests_failed++; $display("FAIL busy_settle: got rerise %b busy %b expected 0/0", rerise, router_busy);
        end
    endtask

    task automatic test_reset_midflight();
        logic [LW-1:0] exp_w;
        apply_reset();
        border_in_valid = 9'h020;
        tx_ready = 1'b1;
        drive_data();
        repeat (3) begin @(negedge clk); step(); end
        tx_ready = 1'b0;
        repeat (2) begin @(negedge clk); step(); end
        @(negedge clk);
        tests_run++; if (tx_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_valid: got %b expected 1", tx_valid); end
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (tx_valid !== 1'b0 || tx_data !== '0) begin
            tests_failed++; $display("FAIL mid_async_clear: got %b/%h expected 0/0", tx_valid, tx_data);
        end
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) sent_b[c] = 0;
        sent_c = 0;
        border_in_valid = 9'h081;
        tx_ready = 1'b1;
        drive_data();
        reset = 1'b0;
        exp_q.push_back(bword(0, 0));
        exp_q.push_back(bword(7, 0));
        for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                tests_run++;
                exp_w = exp_q.pop_front();
                if (tx_data !== exp_w) begin tests_failed++; $display("FAIL mid_tx_word: got %h expected %h", tx_data, exp_w); end
            end
            step();
        end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL mid_timeout: got %0d words left expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        test_reset();
        test_round_robin();
        test_ctrl_burst();
        test_backpressure();
        test_rx_routing();
        test_drop();
        test_busy_hold();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
